// File: rtl/kexp_ctrl.sv
// Per-block sequencer for kexp: holds key/direction, restarts kexp per block, forwards NR+1 round keys.
// Optional RUN watchdog enabled by defining KEXP_CTRL_WDOG_EN.
module kexp_ctrl #(
    parameter int NR       = 10,
    parameter int WDOG_CYC = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_wr,
    input  logic [127:0] key_in,
    input  logic         key_enc,
    output logic         key_rdy,
    input  logic         blk_vld,
    output logic         blk_rdy,
    output logic         blk_done,
    output logic         err,
    output logic         key_ld_p,
    output logic [127:0] key,
    output logic         enc,
    input  logic         rk_vld,
    input  logic [127:0] rk,
    output logic         rk_rdy,
    input  logic         dp_rdy,
    output logic         rnd_en,
    output logic [127:0] rnd_key,
    output logic [3:0]   rnd_idx,
    output logic         rnd_first,
    output logic         rnd_last
);

    if (NR < 1 || NR > 14 || WDOG_CYC < 2) begin : g_bad_param
        $error("kexp_ctrl: NR must be 1..14 and WDOG_CYC at least 2");
    end

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t state, state_nxt;
    logic   key_ok;
    logic   accept;
    logic   last_hs;
    logic   wdog_exp;

    assign key_rdy   = (state == IDLE);
    // A key write in the same cycle wins; the block waits and uses the new key.
    assign blk_rdy   = key_rdy && key_ok && !key_wr;
    assign accept    = blk_vld && blk_rdy;
    assign rk_rdy    = (state == RUN) && dp_rdy;
    assign rnd_en    = rk_vld && rk_rdy;
    assign rnd_key   = rk;
    assign rnd_first = (rnd_idx == 4'd0);
    assign rnd_last  = (rnd_idx == 4'(NR));
    assign last_hs   = rnd_en && rnd_last;

`ifdef KEXP_CTRL_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] wdog_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            wdog_cnt <= '0;
        else if (state != RUN || rk_vld)
            wdog_cnt <= '0;
        else
            wdog_cnt <= wdog_cnt + 1'b1;
    end

    // Expires on the cycle the count would reach WDOG_CYC.
    assign wdog_exp = (state == RUN) && !rk_vld && (wdog_cnt == WW'(WDOG_CYC - 1));
`else
    assign wdog_exp = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = LOAD;
            LOAD: state_nxt = RUN;
            RUN: begin
                if (last_hs)       state_nxt = DONE;
                else if (wdog_exp) state_nxt = IDLE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            key_ok   <= 1'b0;
            key      <= '0;
            enc      <= 1'b0;
            rnd_idx  <= 4'd0;
            key_ld_p <= 1'b0;
            blk_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            key_ld_p <= accept;
            blk_done <= last_hs;
            err      <= wdog_exp;
            if (key_rdy && key_wr) begin
                key    <= key_in;
                enc    <= key_enc;
                key_ok <= 1'b1;
            end
            if (state == LOAD)
                rnd_idx <= 4'd0;
            else if (rnd_en && !rnd_last)
                rnd_idx <= rnd_idx + 4'd1;
        end
    end

endmodule

// File: doc/kexp_ctrl.md
# kexp_ctrl

Per-block sequencer for the AES key-expansion unit `kexp`. It holds the host's cipher key and direction, then restarts `kexp` for every data block with a one-cycle `key_ld_p` pulse. It pulls the NR+1 round keys over the `rk_vld`/`rk_rdy` handshake and forwards each one to the round datapath with round-index and first/last strobes. It sits between the host/block interface and the `kexp` + round-datapath pair.

## Interface
- `NR`, 10: number of rounds; NR+1 round keys are consumed per block.
- `WDOG_CYC`, 64: watchdog limit in cycles (used only with `KEXP_CTRL_WDOG_EN`).
- `clk` in 1: the only clock.
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `key_wr` in 1: host key write strobe.
- `key_in` in 128: cipher key.
- `key_enc` in 1: direction; 1 = encrypt, 0 = decrypt.
- `key_rdy` out 1: controller can accept `key_wr`.
- `blk_vld` in 1: host requests processing of one block.
- `blk_rdy` out 1: controller accepts the block request.
- `blk_done` out 1: one-cycle pulse after the last round key is delivered.
- `err` out 1: one-cycle watchdog error pulse.
- `key_ld_p` out 1: to `kexp`; one-cycle key-load pulse.
- `key` out 128: to `kexp`; stored key.
- `enc` out 1: to `kexp`; stored direction.
- `rk_vld` in 1: from `kexp`; round key valid.
- `rk` in 128: from `kexp`; round key.
- `rk_rdy` out 1: to `kexp`; round key accepted.
- `dp_rdy` in 1: round datapath can take a round this cycle.
- `rnd_en` out 1: round strobe to the datapath.
- `rnd_key` out 128: round key to the datapath.
- `rnd_idx` out 4: round number, 0..NR.
- `rnd_first` out 1: high when `rnd_idx`==0.
- `rnd_last` out 1: high when `rnd_idx`==NR.

## Operation
- FSM states and transitions:
  - IDLE -> LOAD on `blk_vld && blk_rdy`.
  - LOAD -> RUN unconditionally after one cycle.
  - RUN -> DONE on the handshake at `rnd_idx`==NR.
  - DONE -> IDLE unconditionally after one cycle.
  - RUN -> IDLE on watchdog expiry.
- Key registers:
  - `key_rdy` = IDLE.
  - `key_wr` in IDLE captures `key_in`/`key_enc` into `key`/`enc` and sets `key_ok`.
  - `key_wr` outside IDLE is ignored.
- Block acceptance:
  - `blk_rdy` = IDLE && `key_ok` && !`key_wr`.
  - A simultaneous key write wins; the block request waits one cycle and then uses the new key.
- `key_ld_p` is registered and high for exactly the LOAD cycle.
- `key` and `enc` are held stable from acceptance through DONE.
- Round handshake:
  - `rk_rdy` = RUN && `dp_rdy`.
  - `rnd_en` = `rk_vld` && `rk_rdy`.
  - `rnd_key` = `rk` (combinational pass-through).
- `rnd_idx`:
  - Cleared in LOAD.
  - Increments on each `rnd_en`.
  - Never exceeds NR; 4-bit, so NR ≤ 14.
- `rnd_first` and `rnd_last` are decoded from `rnd_idx`. They are valid on `rnd_en`.
- `rk_vld` outside RUN is ignored; `rk_rdy` is 0 there.
- The round order (forward/inverse) is supplied by `kexp` from `enc`. The controller only counts.

## Timing
- Reset (`rst_n`=0 at a rising edge) values:
  - State IDLE, `key_ok`=0, `key`=0, `enc`=0, `rnd_idx`=0.
  - `key_ld_p`=0, `blk_done`=0, `err`=0.
  - `key_rdy`=1, `blk_rdy`=0.
- Reset mid-block aborts without `blk_done`. A key must be rewritten before the next block.
- No-stall latency, with block accepted at cycle T:
  - `key_ld_p` at T+1.
  - First `rnd_en` at T+2 at the earliest.
  - Last `rnd_en` at T+2+NR.
  - `blk_done` at T+3+NR.
  - `blk_rdy` again at T+4+NR.
- Stalls from `dp_rdy`=0 or `rk_vld`=0 add cycles one for one. No round key is dropped or duplicated.
- `blk_done` and `err` are never high in the same cycle.

## Configuration
- `KEXP_CTRL_WDOG_EN` defined:
  - A counter clears on entering RUN and on every cycle with `rk_vld`=1, and increments otherwise in RUN.
  - When it reaches `WDOG_CYC`, the controller pulses `err` for one cycle and goes to IDLE.
  - No `blk_done` is issued; `key_ok` is kept.
- Not defined: `err` is tied to 0, no counter exists, and RUN waits indefinitely.

## Test plan
- Write key 0x2b7e1516_28aed2a6_abf71588_09cf4f3c with enc=1, then request a block, with `kexp` and `dp_rdy`=1 -> `key_ld_p` at T+1, 11 `rnd_en` with `rnd_idx` 0..10, `rnd_key`[10]=0xd014f9a8_c9ee2589_e13f0cc8_b6630ca6, `blk_done` at T+13.
- Same key with enc=0 -> first `rnd_key` = 0xd014f9a8..., last = 0x2b7e1516...; `rnd_first`/`rnd_last` on indices 0/10.
- Toggle `dp_rdy` 1/0 every cycle during RUN -> exactly 11 `rnd_en`, `rk_rdy` low on stall cycles, `blk_done` at T+23.
- `blk_vld` before any key -> `blk_rdy`=0, no `key_ld_p`. Then `key_wr` and `blk_vld` in the same cycle -> key captured, block accepted the next cycle with the new key.
- Assert `rst_n`=0 for one cycle at `rnd_idx`=5 -> all outputs at reset values, no `blk_done`, `blk_rdy`=0 until a key is rewritten.
- With `KEXP_CTRL_WDOG_EN`, `WDOG_CYC`=64, hold `rk_vld`=0 after round 3 -> `err` pulse 64 cycles later, state IDLE, `blk_rdy`=1 the next cycle. Without the macro -> no `err`, still in RUN.
